lane_traffic_engine: RTL and testbench

//  Parametrised multi-lane obstacle engine for the Frogger VGA playfield. Owns NUM_LANES cars:
//  one per lane, with direction alternating by lane, per-lane speed scaled by game level,
//  and seamless horizontal wrap. Produces a registered car-pixel flag for the RGB mux and
//  per-frame frog/car collision detection, with a post-hit freeze. Sits beside the VGA

---
 rtl/lane_traffic_engine.sv | 180 ++++++++++++++++++
 tb/tb_lane_traffic_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lane_traffic_engine.sv
// Multi-lane car engine for the Frogger playfield: per-frame car motion with wrap,
// registered car-pixel flag, frog/car collision detection and a post-hit freeze.
module lane_traffic_engine #(
  parameter int NUM_LANES     = 4,
  parameter int H_DISPLAY     = 640,
  parameter int CELL          = 32,
  parameter int FIRST_ROW     = 10,
  parameter int BASE_STEP     = 1,
  parameter int LANE_STEP_INC = 1,
  parameter int MAX_STEP      = 16,
  parameter int LANE_SPACING  = 160,
  parameter int FREEZE_FRAMES = 60
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_Frame_Start,
  input  logic                    i_Pause,
  input  logic [3:0]              i_Level,
  input  logic [9:0]              i_H_Count,
  input  logic [9:0]              i_V_Count,
  input  logic [9:0]              i_Frog_X,
  input  logic [9:0]              i_Frog_Y,
  output logic                    o_Car_Pixel,
  output logic [2:0]              o_Car_Lane,
  output logic                    o_Collision,
  output logic [2:0]              o_Hit_Lane,
  output logic                    o_Frozen,
  output logic [NUM_LANES*10-1:0] o_Car_X_Flat
);

  localparam int          V_DISPLAY   = 480;
  localparam logic [15:0] FREEZE_LOAD = 16'((FREEZE_FRAMES > 0) ? FREEZE_FRAMES - 1 : 0);

  typedef enum logic {RUN, FREEZE} state_e;

  state_e      state_q, state_d;
  logic [15:0] frz_cnt_q, frz_cnt_d;
  logic [9:0]  x_q [NUM_LANES];
  logic [9:0]  x_d [NUM_LANES];
  logic        coll_q, coll_d;
  logic [2:0]  hit_lane_q, hit_lane_d;
  logic        pix_q, pix_d;
  logic [2:0]  car_lane_q, car_lane_d;
  logic        move;
  logic        hit_any;
  logic [2:0]  hit_lane;

  function automatic logic [7:0] lane_step(input int lane, input logic [3:0] lvl);
    logic [7:0] s;
    s = 8'(BASE_STEP + lane * LANE_STEP_INC) + {4'b0000, lvl};
    if (s > 8'(MAX_STEP)) s = 8'(MAX_STEP);
    return s;
  endfunction

  function automatic logic [9:0] advance(input logic [9:0] x, input logic [7:0] step,
                                         input logic left);
    logic [10:0] t;
    if (left) begin
      if ({1'b0, x} < {3'b000, step}) t = {1'b0, x} + 11'(H_DISPLAY) - {3'b000, step};
      else                            t = {1'b0, x} - {3'b000, step};
    end else begin
      t = {1'b0, x} + {3'b000, step};
      if (t >= 11'(H_DISPLAY)) t = t - 11'(H_DISPLAY);
    end
    return t[9:0];
  endfunction

  // Square query box of side qsz at (qx,qy) against lane's car, including the wrapped tail.
  function automatic logic overlaps(input logic [9:0] cx, input int lane,
                                    input logic [9:0] qx, input logic [9:0] qy,
                                    input logic [11:0] qsz);
    logic [11:0] cx0, cx1, cy0, cy1, qx0, qx1, qy0, qy1;
    logic        xhit;
    cx0  = {2'b00, cx};
    cx1  = cx0 + 12'(CELL);
    cy0  = 12'((FIRST_ROW + lane) * CELL);
    cy1  = cy0 + 12'(CELL);
    qx0  = {2'b00, qx};
    qx1  = qx0 + qsz;
    qy0  = {2'b00, qy};
    qy1  = qy0 + qsz;
    xhit = (qx0 < cx1) && (cx0 < qx1);
    if (cx1 > 12'(H_DISPLAY)) xhit = xhit || (qx0 < cx1 - 12'(H_DISPLAY));
    return xhit && (qy0 < cy1) && (cy0 < qy1);
  endfunction

  always_comb begin
    hit_any  = 1'b0;
    hit_lane = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (overlaps(x_q[i], i, i_Frog_X, i_Frog_Y, 12'(CELL))) begin
        hit_any  = 1'b1;
        hit_lane = 3'(i);
      end
    end
  end

  always_comb begin
    pix_d      = 1'b0;
    car_lane_d = '0;
    if ((i_H_Count < 10'(H_DISPLAY)) && (i_V_Count < 10'(V_DISPLAY))) begin
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
        if (overlaps(x_q[i], i, i_H_Count, i_V_Count, 12'd1)) begin
          pix_d      = 1'b1;
          car_lane_d = 3'(i);
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    frz_cnt_d  = frz_cnt_q;
    coll_d     = 1'b0;
    hit_lane_d = hit_lane_q;
    move       = 1'b0;
    case (state_q)
      RUN: begin
        if (i_Frame_Start && !i_Pause) begin
          if (hit_any) begin
            coll_d     = 1'b1;
            hit_lane_d = hit_lane;
            if (FREEZE_FRAMES > 0) begin
              state_d   = FREEZE;
              frz_cnt_d = FREEZE_LOAD;
            end
          end else begin
            move = 1'b1;
          end
        end
      end
      FREEZE: begin
        // Countdown ignores pause; the frame that sees zero only resumes, it does not move.
        if (i_Frame_Start) begin
          if (frz_cnt_q == '0) state_d   = RUN;
          else                 frz_cnt_d = frz_cnt_q - 16'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      x_d[i] = x_q[i];
      if (move) x_d[i] = advance(x_q[i], lane_step(i, i_Level), 1'(i & 1));
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= RUN;
      frz_cnt_q  <= '0;
      coll_q     <= 1'b0;
      hit_lane_q <= '0;
      pix_q      <= 1'b0;
      car_lane_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) x_q[i] <= 10'((i * LANE_SPACING) % H_DISPLAY);
    end else begin
      state_q    <= state_d;
      frz_cnt_q  <= frz_cnt_d;
      coll_q     <= coll_d;
      hit_lane_q <= hit_lane_d;
      pix_q      <= pix_d;
      car_lane_q <= car_lane_d;
      for (int i = 0; i < NUM_LANES; i++) x_q[i] <= x_d[i];
    end
  end

  assign o_Car_Pixel = pix_q;
  assign o_Car_Lane  = car_lane_q;
  assign o_Collision = coll_q;
  assign o_Hit_Lane  = hit_lane_q;
  assign o_Frozen    = (state_q == FREEZE);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_flat
    assign o_Car_X_Flat[g*10 +: 10] = x_q[g];
  end

endmodule

// File: tb/tb_lane_traffic_engine.sv
// Directed bench for lane_traffic_engine with a scoreboard queue and a position model.
module tb_lane_traffic_engine;

  logic        clk = 1'b0;
  logic        rst_n, fs, pause;
  logic [3:0]  level;
  logic [9:0]  hc, vc, fx, fy;
  logic        car_pix, coll, frozen;
  logic [2:0]  car_lane, hit_lane;
  logic [39:0] xflat;

  always #5 clk = ~clk;

  lane_traffic_engine dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Frame_Start(fs), .i_Pause(pause), .i_Level(level),
    .i_H_Count(hc), .i_V_Count(vc), .i_Frog_X(fx), .i_Frog_Y(fy),
    .o_Car_Pixel(car_pix), .o_Car_Lane(car_lane), .o_Collision(coll), .o_Hit_Lane(hit_lane),
    .o_Frozen(frozen), .o_Car_X_Flat(xflat)
  );

  typedef struct { string tag; logic [63:0] exp; } exp_t;
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   mx[4];
  int   m_level  = 0;

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d required none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d required %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    push(tag, exp);
    pop_check(obs);
  endtask

  function automatic int step_of(input int i);
    int s;
    s = 1 + i + m_level;
    if (s > 16) s = 16;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mx[i] = (i * 160) % 640;
  endtask

  task automatic model_move();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) mx[i] = (mx[i] + step_of(i)) % 640;
      else            mx[i] = (mx[i] + 640 - step_of(i)) % 640;
    end
  endtask

  function automatic logic [39:0] model_flat();
    logic [39:0] f;
    for (int i = 0; i < 4; i++) f[i*10 +: 10] = 10'(mx[i]);
    return f;
  endfunction

  task automatic set_level(input int l);
    @(negedge clk);
    level   = 4'(l);
    m_level = l;
  endtask

  task automatic frame(input bit moves, input string tag);
    @(negedge clk);
    fs = 1'b1;
    if (moves) model_move();
    push(tag, 64'(model_flat()));
    @(negedge clk);
    fs = 1'b0;
    pop_check(64'(xflat));
  endtask

  task automatic pix(input int h, input int v, input bit ep, input int el, input string tag);
    @(negedge clk);
    hc = 10'(h);
    vc = 10'(v);
    push({tag, "_pix"}, 64'(ep));
    push({tag, "_lane"}, 64'(el));
    @(negedge clk);
    pop_check(64'(car_pix));
    pop_check(64'(car_lane));
  endtask

  task automatic check_flags(input string tag, input bit c, input int hl, input bit fz);
    check({tag, "_coll"}, 64'(coll), 64'(c));
    check({tag, "_hitlane"}, 64'(hit_lane), 64'(hl));
    check({tag, "_frozen"}, 64'(frozen), 64'(fz));
  endtask

  // Reset is asserted mid-cycle and checked before the next clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_x"}, 64'(xflat), 64'(model_flat()));
    check_flags(tag, 1'b0, 0, 1'b0);
    check({tag, "_pix"}, 64'(car_pix), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; fs = 1'b0; pause = 1'b0; level = 4'd0;
    hc = '0; vc = '0; fx = '0; fy = '0;

    do_reset("rst1");
    repeat (3) @(negedge clk);
    check("rst_x_stable", 64'(xflat), 64'({10'd480, 10'd320, 10'd160, 10'd0}));
    check_flags("rst_idle", 1'b0, 0, 1'b0);

    pix(330, 384, 1'b1, 2, "lane2_body");
    pix(700, 384, 1'b0, 0, "h_offscreen");
    pix(330, 500, 1'b0, 0, "v_offscreen");
    pix(352, 384, 1'b0, 0, "lane2_right_edge");

    frame(1'b1, "lvl0_f1");
    check("lvl0_f1_const", 64'(xflat), 64'({10'd476, 10'd323, 10'd158, 10'd1}));
    for (int k = 0; k < 15; k++) frame(1'b1, "lvl0_run");
    check("lane0_at16", 64'(xflat[9:0]), 64'd16);

    fx = 10'd0; fy = 10'd320;
    frame(1'b0, "hit_nomove");
    check_flags("hit", 1'b1, 0, 1'b1);
    @(negedge clk);
    check_flags("hit_next", 1'b0, 0, 1'b1);
    for (int k = 0; k < 59; k++) begin
      pause = (k < 10);
      frame(1'b0, "freeze_hold");
    end
    pause = 1'b0;
    check_flags("freeze_last", 1'b0, 0, 1'b1);
    fy = 10'd0;
    frame(1'b0, "freeze_exit");
    check_flags("freeze_exit", 1'b0, 0, 1'b0);
    frame(1'b1, "post_freeze_move");

    pause = 1'b1;
    for (int k = 0; k < 5; k++) frame(1'b0, "pause_hold");
    pause = 1'b0;
    frame(1'b1, "unpause_move");

    fx = 10'(mx[1]); fy = 10'd352;
    frame(1'b0, "hit_lane1");
    check_flags("hit_l1", 1'b1, 1, 1'b1);
    frame(1'b0, "l1_freeze");
    do_reset("rst_mid_freeze");

    fx = 10'd32; fy = 10'd320;
    frame(1'b1, "touch_edge");
    check_flags("touch", 1'b0, 0, 1'b0);
    fy = 10'd0;

    do_reset("rst3");
    set_level(15);
    for (int k = 0; k < 10; k++) frame(1'b1, "lvl15_run");
    check("lane3_sat", 64'(xflat[39:30]), 64'd320);
    for (int k = 0; k < 29; k++) frame(1'b1, "lvl15_run2");
    set_level(0);
    for (int k = 0; k < 6; k++) frame(1'b1, "to630");
    check("lane0_630", 64'(xflat[9:0]), 64'd630);
    pix(5, 320, 1'b1, 0, "wrap_tail");
    pix(21, 320, 1'b1, 0, "wrap_tail_last");
    pix(22, 320, 1'b0, 0, "wrap_tail_end");
    pix(629, 320, 1'b0, 0, "before_car");
    pix(630, 320, 1'b1, 0, "car_start");
    for (int k = 0; k < 9; k++) frame(1'b1, "to639");
    check("lane0_639", 64'(xflat[9:0]), 64'd639);
    frame(1'b1, "wrap_right");
    check("lane0_wrap0", 64'(xflat[9:0]), 64'd0);

    do_reset("rst4");
    set_level(1);
    for (int k = 0; k < 53; k++) frame(1'b1, "lvl1_run");
    check("lane1_at1", 64'(xflat[19:10]), 64'd1);
    set_level(0);
    frame(1'b1, "wrap_left");
    check("lane1_wrap639", 64'(xflat[19:10]), 64'd639);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
